// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, taken-branch squashes,
// multi-cycle data-memory freezes, plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W      = 5,
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int COUNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [COUNT_W-1:0]    stall_cnt,
  output logic [COUNT_W-1:0]    flush_cnt
);
  localparam int   WCNT_W = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
  localparam logic FRZ_EN = (MEM_WAIT_CYCLES > 0);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              freeze_entry, frozen, load_use, branch, stall;

  always_comb begin
    freeze_entry = (state == RUN) && mem_req && FRZ_EN;
    frozen       = freeze_entry || ((state == MEM_WAIT) && (wcnt != '0));
    load_use     = ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    // Branch and load-use only act in RUN; the release cycle just lets the
    // stalled instruction advance.
    branch       = (state == RUN) && !freeze_entry && branch_taken;
    stall        = (state == RUN) && !freeze_entry && !branch_taken && load_use;

    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      if (frozen) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (branch) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (stall) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: if (freeze_entry) begin
          state <= MEM_WAIT;
          wcnt  <= WCNT_W'(MEM_WAIT_CYCLES - 1);
        end
        MEM_WAIT: if (wcnt == '0) state <= RUN;
                  else            wcnt  <= wcnt - 1'b1;
        default: state <= RUN;
      endcase
      if (!pc_en && (stall_cnt != '1))     stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle compare against a rule-level model
// plus hand-computed literal checks at key points.
module tb_hazard_ctrl;
  localparam int RW  = 5;
  localparam int MWC = 2;
  localparam int CW  = 4;

  logic          clk = 0, rst = 1;
  logic [RW-1:0] id_rs = 0, id_rt = 0, ex_rd = 0;
  logic          id_uses_rt = 0, ex_mem_read = 0, branch_taken = 0, mem_req = 0;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    dout;

  int checks = 0, errors = 0;
  int m_age = 0, m_stall = 0, m_flush = 0;
  localparam int SAT = (1 << CW) - 1;

  // Output vector order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush
  localparam logic [6:0] O_IDLE = 7'b1111100;
  localparam logic [6:0] O_FRZ  = 7'b0000000;
  localparam logic [6:0] O_BR   = 7'b1111111;
  localparam logic [6:0] O_LU   = 7'b0011101;

  hazard_ctrl #(.REG_ADDR_W(RW), .MEM_WAIT_CYCLES(MWC), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  assign dout = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age counts cycles since the freeze began (0 = not frozen);
  // cycles with age 1..MWC-1 are frozen, age MWC is the release cycle.
  function automatic logic [6:0] model_out();
    logic lu;
    lu = ex_mem_read && ex_rd != 0 &&
         (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    if (rst)                           return O_IDLE;
    if (m_age > 0 && m_age < MWC)      return O_FRZ;
    if (m_age == MWC && MWC > 0)       return O_IDLE;
    if (mem_req && MWC > 0)            return O_FRZ;
    if (branch_taken)                  return O_BR;
    if (lu)                            return O_LU;
    return O_IDLE;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [6:0] e;
    if (rst) begin
      m_age <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      e = model_out();
      if (!e[6]) m_stall <= (m_stall < SAT) ? m_stall + 1 : SAT;
      if (e[1])  m_flush <= (m_flush < SAT) ? m_flush + 1 : SAT;
      if (m_age == MWC && MWC > 0) m_age <= 0;
      else if (m_age > 0)          m_age <= m_age + 1;
      else if (mem_req && MWC > 0) m_age <= 1;
    end
  end

  always @(negedge clk) begin
    check("model_out", 32'(dout), 32'(model_out()));
    check("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("model_flush_cnt", 32'(flush_cnt), 32'(m_flush));
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0;
    ex_mem_read = 0; branch_taken = 0; mem_req = 0;
  endtask

  // Inputs already set; check mid-cycle, then advance past the next edge.
  task automatic step(input string name, input logic [6:0] exp);
    @(negedge clk); #1;
    check(name, 32'(dout), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(dout), 32'(O_IDLE));
    check("reset_stall", 32'(stall_cnt), 0);
    check("reset_flush", 32'(flush_cnt), 0);
    rst = 0;
    step("idle", O_IDLE);

    ex_mem_read = 1; ex_rd = 5; id_rs = 5;
    step("loaduse_rs", O_LU);
    clr();
    step("after_loaduse", O_IDLE);
    check("stall_cnt_lu", 32'(stall_cnt), 1);

    ex_mem_read = 1; ex_rd = 0; id_rs = 0;
    step("zero_reg", O_IDLE);
    clr();
    check("stall_cnt_zero", 32'(stall_cnt), 1);

    ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_rs = 3; id_uses_rt = 0;
    step("rt_unused", O_IDLE);
    id_uses_rt = 1;
    step("rt_used", O_LU);
    clr();
    step("after_rt", O_IDLE);
    check("stall_cnt_rt", 32'(stall_cnt), 2);

    branch_taken = 1; ex_mem_read = 1; ex_rd = 9; id_rs = 9;
    step("branch_lu", O_BR);
    clr();
    step("after_branch", O_IDLE);
    check("flush_cnt_br", 32'(flush_cnt), 1);
    check("stall_cnt_br", 32'(stall_cnt), 2);

    mem_req = 1;
    step("freeze_1", O_FRZ);
    branch_taken = 1;
    step("freeze_2_branch", O_FRZ);
    branch_taken = 0;
    step("release", O_IDLE);
    mem_req = 0;
    step("run_after_freeze", O_IDLE);
    check("stall_cnt_frz", 32'(stall_cnt), 4);
    check("flush_cnt_frz", 32'(flush_cnt), 1);

    // Async reset while in MEM_WAIT
    mem_req = 1;
    step("freeze_pre_rst", O_FRZ);
    #2 rst = 1;
    #1;
    check("async_rst_out", 32'(dout), 32'(O_IDLE));
    check("async_rst_stall", 32'(stall_cnt), 0);
    check("async_rst_flush", 32'(flush_cnt), 0);
    mem_req = 0;
    @(posedge clk); #1;
    rst = 0;
    step("run_after_rst", O_IDLE);
    mem_req = 1;
    step("refreeze_1", O_FRZ);
    mem_req = 0;
    step("refreeze_2", O_FRZ);
    step("refreeze_release", O_IDLE);
    check("stall_cnt_refrz", 32'(stall_cnt), 2);

    ex_mem_read = 1; ex_rd = 4; id_rs = 4;
    repeat (20) @(posedge clk);
    #1;
    check("stall_sat", 32'(stall_cnt), SAT);
    clr();
    branch_taken = 1;
    repeat (20) @(posedge clk);
    #1;
    check("flush_sat", 32'(flush_cnt), SAT);
    clr();
    step("final_idle", O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
